// File: rtl/uart_cmd_wrapper_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_wrapper_if
//   Bundles every non-clock/reset signal of uart_cmd_wrapper.
//
//   slave  : the wrapper's view (receives UART/consumer requests, drives
//            the command, strobes and transmit byte).
//   master : the surrounding system's view (UART receiver/transmitter and
//            command processor).
//
//   rx_rdy      UART receiver holds a valid byte
//   rx_data     received byte
//   clr_rx_rdy  byte-accept strobe back to the receiver
//   cmd         assembled command {opcode, byte 2, byte 3}
//   cmd_rdy     cmd holds a complete, unconsumed command
//   clr_cmd_rdy consumer releases cmd
//   resp_data   response byte to transmit
//   send_resp   request to transmit resp_data
//   resp_sent   one-cycle pulse, response byte fully transmitted
//   trmt        one-cycle start pulse to the UART transmitter
//   tx_data     byte presented to the UART transmitter
//   tx_done     UART transmitter finished its byte
// ----------------------------------------------------------------------------
interface uart_cmd_wrapper_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, resp_data, send_resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, resp_sent, trmt, tx_data
    );

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, resp_data, send_resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, resp_sent, trmt, tx_data
    );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// ----------------------------------------------------------------------------
// uart_cmd_wrapper
//   Assembles three received UART bytes into a 24-bit command and hands
//   single response bytes to a UART transmitter.
//
//   Receive path : BYTE_HI -> BYTE_MID -> BYTE_LO -> CMD_FULL. While the
//                  command is full, received bytes are left pending
//                  (backpressure) until the consumer pulses clr_cmd_rdy.
//   Transmit path: TX_IDLE / TX_BUSY, independent of the receive path.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    uart_cmd_wrapper_if.slave (see interface file for signals)
//
//   Parameter:
//     TIMEOUT_CYCLES  inter-byte timeout in clk cycles (timeout build only)
//
//   Build option:
//     CMD_TIMEOUT_EN  when defined, a partial frame is discarded if the next
//                     byte does not arrive within TIMEOUT_CYCLES cycles.
//                     When undefined, the FSM waits indefinitely.
// ----------------------------------------------------------------------------
module uart_cmd_wrapper #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_cmd_wrapper_if.slave  bus
);

    typedef enum logic [1:0] {
        BYTE_HI,
        BYTE_MID,
        BYTE_LO,
        CMD_FULL
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    rx_state_t   rx_state;
    tx_state_t   tx_state;

    logic [23:0] cmd_q;
    logic        cmd_rdy_q;
    logic [7:0]  tx_data_q;
    logic        trmt_q;
    logic        resp_sent_q;

    logic        rx_accept;
    logic        timeout;

    // A byte is taken whenever the frame is not yet full. The reset term
    // keeps the strobe quiet while the block is held in reset.
    assign rx_accept      = rst_n && bus.rx_rdy && (rx_state != CMD_FULL);
    assign bus.clr_rx_rdy = rx_accept;

    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.resp_sent  = resp_sent_q;

`ifdef CMD_TIMEOUT_EN
    logic [19:0] idle_cnt;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = ((rx_state == BYTE_MID) || (rx_state == BYTE_LO)) &&
                     !bus.rx_rdy &&
                     (idle_cnt == TIMEOUT_CYCLES - 20'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (rx_accept || timeout) begin
            idle_cnt <= '0;
        end else if ((rx_state == BYTE_MID) || (rx_state == BYTE_LO)) begin
            idle_cnt <= idle_cnt + 20'd1;
        end
    end
`else
    assign timeout = 1'b0;

    // The parameter is kept on the port list so both builds share one
    // instantiation; it carries no logic here.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Receive FSM: byte capture and command hand-off.
    // cmd is never cleared outside reset, so the consumer may still read it
    // after releasing cmd_rdy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= BYTE_HI;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            case (rx_state)
                BYTE_HI: begin
                    if (rx_accept) begin
                        cmd_q[23:16] <= bus.rx_data;
                        rx_state     <= BYTE_MID;
                    end
                end
                BYTE_MID: begin
                    if (rx_accept) begin
                        cmd_q[15:8] <= bus.rx_data;
                        rx_state    <= BYTE_LO;
                    end else if (timeout) begin
                        rx_state <= BYTE_HI;
                    end
                end
                BYTE_LO: begin
                    if (rx_accept) begin
                        cmd_q[7:0] <= bus.rx_data;
                        cmd_rdy_q  <= 1'b1;
                        rx_state   <= CMD_FULL;
                    end else if (timeout) begin
                        rx_state <= BYTE_HI;
                    end
                end
                CMD_FULL: begin
                    // A byte pending now is taken from BYTE_HI next cycle.
                    if (bus.clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        rx_state  <= BYTE_HI;
                    end
                end
                default: begin
                    rx_state <= BYTE_HI;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: one response byte at a time.
    // trmt and resp_sent default low each cycle, so each is a single pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (bus.send_resp) begin
                        tx_data_q <= bus.resp_data;
                        trmt_q    <= 1'b1;
                        tx_state  <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (bus.tx_done) begin
                        resp_sent_q <= 1'b1;
                        tx_state    <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_wrapper
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model (byte count, command image, transmitter busy flag) runs
//   alongside the DUT and predicts every output each cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;

    localparam int          T_CYC   = 100;
    localparam logic [19:0] TIMEOUT = 20'd100;

    logic clk;
    logic rst_n;

    uart_cmd_wrapper_if bus();

    uart_cmd_wrapper #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec;
    int n_err;
    int n_clr;      // clr_rx_rdy pulses seen on the DUT
    bit last_acc;   // model accepted a byte in the last cycle
    bit last_clr;   // DUT clr_rx_rdy value in the last cycle

    // ---------------- reference model ----------------
    int          m_cnt;    // bytes collected in current frame (3 = full)
    logic [23:0] m_cmd;
    bit          m_rdy;
    bit          m_busy;
    logic [7:0]  m_tx;
    bit          m_trmt;
    bit          m_sent;
`ifdef CMD_TIMEOUT_EN
    int          m_wait;   // cycles spent waiting inside a partial frame
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_cmd  = 24'h0;
        m_rdy  = 1'b0;
        m_busy = 1'b0;
        m_tx   = 8'h00;
        m_trmt = 1'b0;
        m_sent = 1'b0;
`ifdef CMD_TIMEOUT_EN
        m_wait = 0;
`endif
    endtask

    // Called shortly after a falling edge with this cycle's inputs applied.
    // Checks the accept strobe, advances the model, crosses one rising edge
    // and checks the registered outputs at the following falling edge.
    // One-cycle request pulses are dropped afterwards, as is an accepted byte.
    task automatic tick();
        bit exp_clr;
        #1;
        exp_clr = bus.rx_rdy && (m_cnt != 3);
        check("clr_rx_rdy", bus.clr_rx_rdy, exp_clr);
        last_clr = bus.clr_rx_rdy;
        if (bus.clr_rx_rdy === 1'b1) n_clr++;
        last_acc = exp_clr;

        // receive side
        if (m_cnt == 3) begin
            if (bus.clr_cmd_rdy) begin
                m_cnt = 0;
                m_rdy = 1'b0;
            end
        end else if (exp_clr) begin
            case (m_cnt)
                0:       m_cmd[23:16] = bus.rx_data;
                1:       m_cmd[15:8]  = bus.rx_data;
                default: m_cmd[7:0]   = bus.rx_data;
            endcase
            m_cnt++;
            if (m_cnt == 3) m_rdy = 1'b1;
`ifdef CMD_TIMEOUT_EN
            m_wait = 0;
        end else if (m_cnt != 0) begin
            if (m_wait == T_CYC - 1) begin
                m_cnt  = 0;
                m_wait = 0;
            end else begin
                m_wait++;
            end
`endif
        end

        // transmit side
        m_trmt = 1'b0;
        m_sent = 1'b0;
        if (!m_busy) begin
            if (bus.send_resp) begin
                m_tx   = bus.resp_data;
                m_trmt = 1'b1;
                m_busy = 1'b1;
            end
        end else if (bus.tx_done) begin
            m_sent = 1'b1;
            m_busy = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
        check("cmd",       bus.cmd,       m_cmd);
        check("cmd_rdy",   bus.cmd_rdy,   m_rdy);
        check("trmt",      bus.trmt,      m_trmt);
        check("tx_data",   bus.tx_data,   m_tx);
        check("resp_sent", bus.resp_sent, m_sent);

        if (last_acc) bus.rx_rdy = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.tx_done     = 1'b0;
    endtask

    // Present a byte and hold it until the DUT takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = last_acc;
        end
        if (!done) check("send_byte_bound", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset with a byte pending, checking reset values.
    task automatic do_reset();
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h5A;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_cmd",        bus.cmd,        24'h0);
        check("rst_cmd_rdy",    bus.cmd_rdy,    1'b0);
        check("rst_trmt",       bus.trmt,       1'b0);
        check("rst_resp_sent",  bus.resp_sent,  1'b0);
        check("rst_tx_data",    bus.tx_data,    8'h00);
        check("rst_clr_rx_rdy", bus.clr_rx_rdy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.rx_rdy      = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.tx_done     = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int clr_before;
        n_vec = 0;
        n_err = 0;
        n_clr = 0;
        rst_n = 1'b0;
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp_data   = 8'h00;
        bus.send_resp   = 1'b0;
        bus.tx_done     = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        idle(2);

        // ---- three-byte frame ----
        clr_before = n_clr;
        send_byte(8'h02);
        send_byte(8'h0D);
        send_byte(8'hFF);
        check("frame_cmd",     bus.cmd,     24'h020DFF);
        check("frame_cmd_rdy", bus.cmd_rdy, 1'b1);
        check("frame_clr_cnt", n_clr - clr_before, 3);

        // ---- backpressure while full, then release ----
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h11;
        clr_before  = n_clr;
        idle(50);
        check("bp_no_clr",  n_clr - clr_before, 0);
        check("bp_cmd_rdy", bus.cmd_rdy, 1'b1);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        check("rel_clr_same_cycle", last_clr, 1'b0);
        check("rel_cmd_rdy",        bus.cmd_rdy, 1'b0);
        check("rel_cmd_held",       bus.cmd, 24'h020DFF);
        tick();
        check("rel_pending_taken",  last_clr, 1'b1);
        send_byte(8'h22);
        send_byte(8'h33);
        check("frame2_cmd", bus.cmd, 24'h112233);
        bus.clr_cmd_rdy = 1'b1;
        tick();

        // clr_cmd_rdy outside CMD_FULL has no effect
        send_byte(8'h44);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        send_byte(8'h55);
        send_byte(8'h66);
        check("stray_clr_cmd", bus.cmd, 24'h445566);
        bus.clr_cmd_rdy = 1'b1;
        tick();

        // ---- transmit handshake ----
        bus.resp_data = 8'hA5;
        bus.send_resp = 1'b1;
        tick();
        check("tx_trmt",    bus.trmt,    1'b1);
        check("tx_data_a5", bus.tx_data, 8'hA5);
        tick();
        check("tx_trmt_one", bus.trmt, 1'b0);
        bus.resp_data = 8'h3C;
        bus.send_resp = 1'b1;
        tick();
        check("tx_busy_ignore_trmt", bus.trmt,    1'b0);
        check("tx_busy_ignore_data", bus.tx_data, 8'hA5);
        bus.tx_done = 1'b1;
        tick();
        check("tx_resp_sent", bus.resp_sent, 1'b1);
        tick();
        check("tx_resp_sent_one", bus.resp_sent, 1'b0);
        bus.tx_done = 1'b1;
        tick();
        check("tx_idle_done_ignored", bus.resp_sent, 1'b0);

        // ---- inter-byte gap ----
`ifdef CMD_TIMEOUT_EN
        send_byte(8'h01);
        idle(T_CYC + 5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h80);
        check("to_cmd",     bus.cmd,     24'h030080);
        check("to_cmd_rdy", bus.cmd_rdy, 1'b1);
`else
        send_byte(8'h01);
        idle(T_CYC + 5);
        send_byte(8'h03);
        send_byte(8'h00);
        check("gap_cmd",     bus.cmd,     24'h010300);
        check("gap_cmd_rdy", bus.cmd_rdy, 1'b1);
`endif
        bus.clr_cmd_rdy = 1'b1;
        tick();

        // ---- reset mid-frame and mid-transmit ----
        send_byte(8'h77);
        send_byte(8'h88);
        bus.resp_data = 8'hC3;
        bus.send_resp = 1'b1;
        tick();
        do_reset();
        bus.tx_done = 1'b1;
        tick();
        check("post_rst_no_sent", bus.resp_sent, 1'b0);
        idle(3);
        send_byte(8'h9A);
        send_byte(8'hBC);
        send_byte(8'hDE);
        check("post_rst_cmd",     bus.cmd,     24'h9ABCDE);
        check("post_rst_cmd_rdy", bus.cmd_rdy, 1'b1);

        // ---- randomized traffic ----
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            if (!bus.rx_rdy && ($urandom_range(0, 2) == 0)) begin
                bus.rx_rdy  = 1'b1;
                bus.rx_data = 8'($urandom);
            end
            bus.clr_cmd_rdy = ($urandom_range(0, 3) == 0);
            bus.send_resp   = ($urandom_range(0, 4) == 0);
            bus.resp_data   = 8'($urandom);
            bus.tx_done     = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 20'd500000, inter-byte timeout in clk cycles; used only when CMD_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  system clock; every register is updated on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: rx_rdy  input  1  UART receiver holds a valid byte.
REQ-005 Port: rx_data  input  8  received byte.
REQ-006 Port: clr_rx_rdy  output  1  byte-accept strobe to the UART receiver.
REQ-007 Port: cmd  output  24  assembled command; [23:16]=opcode, [15:8]=byte 2, [7:0]=byte 3.
REQ-008 Port: cmd_rdy  output  1  cmd holds a complete, unconsumed command.
REQ-009 Port: clr_cmd_rdy  input  1  command consumer releases cmd.
REQ-010 Port: resp_data  input  8  response byte from the command processor.
REQ-011 Port: send_resp  input  1  request to transmit resp_data.
REQ-012 Port: resp_sent  output  1  one-cycle pulse; the response byte has completed transmission.
REQ-013 Port: trmt  output  1  one-cycle start pulse to the UART transmitter.
REQ-014 Port: tx_data  output  8  byte to the UART transmitter.
REQ-015 Port: tx_done  input  1  UART transmitter finished its byte.

Function
REQ-016 The receive FSM SHALL have states BYTE_HI, BYTE_MID, BYTE_LO and CMD_FULL.
REQ-017 In BYTE_HI, BYTE_MID and BYTE_LO, rx_rdy=1 SHALL assert clr_rx_rdy combinationally in that cycle, capture rx_data into cmd[23:16], [15:8] and [7:0] respectively at the clock edge, and advance to the next state.
REQ-018 Capture of byte 3 SHALL enter CMD_FULL with cmd_rdy=1 from the next cycle; latency from byte 3 accept to cmd_rdy is 1 clk.
REQ-019 In CMD_FULL, rx_rdy SHALL be ignored: clr_rx_rdy=0 and no capture. This backpressures the receiver.
REQ-020 In CMD_FULL, clr_cmd_rdy=1 SHALL clear cmd_rdy and return to BYTE_HI at the next edge.
REQ-021 A byte pending during the clr_cmd_rdy cycle SHALL be accepted no earlier than the following cycle.
REQ-022 clr_cmd_rdy in any state other than CMD_FULL SHALL have no effect.
REQ-023 cmd SHALL hold its value until overwritten byte-wise by a new frame, so a consumer may read it after clearing cmd_rdy.
REQ-024 The transmit FSM SHALL have states TX_IDLE and TX_BUSY and SHALL be independent of the receive FSM.
REQ-025 In TX_IDLE, send_resp=1 SHALL latch resp_data into tx_data, pulse trmt for exactly one cycle at the next edge, and enter TX_BUSY.
REQ-026 send_resp SHALL be ignored while in TX_BUSY.
REQ-027 In TX_BUSY, tx_done=1 SHALL produce a resp_sent pulse of exactly one cycle at the next edge and return to TX_IDLE.
REQ-028 tx_done while in TX_IDLE SHALL be ignored.
REQ-029 tx_data SHALL be stable from the trmt pulse until the next accepted send_resp.

Reset
REQ-030 While rst_n=0: receive FSM=BYTE_HI, transmit FSM=TX_IDLE, cmd=24'h000000, tx_data=8'h00, and cmd_rdy, trmt, resp_sent, clr_rx_rdy all 0.
REQ-031 Reset asserted mid-frame or mid-transmit SHALL discard the partial frame or transaction; no resp_sent SHALL follow the release of reset.

Configuration
REQ-032 Macro CMD_TIMEOUT_EN: when defined, a 20-bit counter SHALL clear on every accepted byte and count while in BYTE_MID or BYTE_LO.
REQ-033 With CMD_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES-1 without rx_rdy SHALL return the FSM to BYTE_HI, discarding the partial frame; cmd_rdy stays 0.
REQ-034 With CMD_TIMEOUT_EN defined, rx_rdy in the same cycle as expiry SHALL win: the byte is accepted and no timeout occurs.
REQ-035 Without CMD_TIMEOUT_EN, no counter SHALL exist and the FSM SHALL wait indefinitely between bytes.

Verification
REQ-036 Bytes 8'h02, 8'h0D, 8'hFF, each held until clr_rx_rdy -> cmd=24'h020DFF and cmd_rdy=1 one clk after the third accept; exactly three clr_rx_rdy pulses.
REQ-037 Leave cmd_rdy set 50 clks with rx_rdy=1 -> no clr_rx_rdy. Then pulse clr_cmd_rdy -> cmd_rdy=0 next clk, and the pending byte is accepted one clk later.
REQ-038 send_resp with resp_data=8'hA5 -> trmt=1 for one clk with tx_data=8'hA5. A second send_resp before tx_done -> ignored. tx_done -> single resp_sent pulse.
REQ-039 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, send byte 8'h01 and idle 100 clks, then send 8'h03, 8'h00, 8'h80 -> cmd=24'h030080 with cmd_rdy=1.
REQ-040 Pull rst_n low after byte 2 and during TX_BUSY -> all outputs at reset values. After release, three fresh bytes assemble a correct cmd, and no stray resp_sent occurs.
